dvp_frame_gen: RTL and testbench
================================

// Module: dvp_frame_gen
// PURPOSE
//  Camera-side DVP transmitter: emits OV7670-style frames (Vsyn, Href, 8-bit data) built from internal test patterns.
//  Drives the capture path's Href/Vsyn/data inputs, so capture and FIFO can be brought up without a sensor.
//  Pixel format: RGB565, two bytes per pixel, high byte first; one byte per clk cycle.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line (2*H_ACTIVE data bytes)
//  H_BLANK   144  blank byte-cycles after active bytes on each line
//  V_SYNC    3    lines with Vsyn high at frame start
//  V_BACK    17   blank lines after sync
//  V_ACTIVE  480  lines carrying Href
//  V_FRONT   10   blank lines after the active lines
//  LINE_LEN = 2*H_ACTIVE+H_BLANK (derived); counter widths = $clog2 of each span
// PORTS
//  clk          in   1   byte clock; all outputs change on posedge
//  rst          in   1   asynchronous reset, active-low
//  capture      in   1   level; 1 = run frames continuously
//  pattern_sel  in   2   0 bars, 1 gradient, 2 frame-count fill, 3 checkerboard
//  Vsyn         out  1   frame sync, active high
//  Href         out  1   high only during active data bytes
//  data         out  8   pixel byte; 8'h00 whenever Href=0
//  frame_done   out  1   1-cycle pulse on last byte-cycle of V_FRONT
//  busy         out  1   1 from the first Vsyn cycle until return to IDLE
//  frame_crc    out  16  see CONFIGURATION
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-frame): Vsyn=Href=frame_done=busy=0, data=0, frame_crc=0, state IDLE, counters 0.
//  FSM: IDLE -> SYNC -> BACK -> ACTIVE -> FRONT -> (SYNC | IDLE).
//  IDLE: capture=1 sampled at edge t -> Vsyn=1, busy=1 from edge t+1 (1-cycle latency); pattern_sel latched here.
//  Each state lasts (its line count)*LINE_LEN cycles; hcnt wraps 0..LINE_LEN-1, vcnt increments on wrap.
//  ACTIVE: Href=1 when hcnt<2*H_ACTIVE; byte 2k = pix[15:8], byte 2k+1 = pix[7:0], pixel k = hcnt>>1.
//  FRONT end: frame_done pulses; capture=1 then -> SYNC on next edge (no gap), pattern_sel relatched; else IDLE.
//  capture dropping mid-frame: frame completes; it is never truncated.
//  pattern_sel changes mid-frame: ignored until next frame start.
//  Patterns: 0 = 8 equal bars (H_ACTIVE/8 px) white,yellow,cyan,green,magenta,red,blue,black;
//   1 = {R=x[4:0],G=x[5:0],B=y[4:0]} mod width; 2 = solid {frame_cnt[7:0],frame_cnt[7:0]};
//   3 = white if x[3]^y[3] else black. frame_cnt: 8-bit, +1 per frame_done, wraps 255->0.
//  Vsyn high for exactly V_SYNC*LINE_LEN cycles; Href never high outside ACTIVE.
// CONFIGURATION
//  DVP_FRAME_GEN_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over every Href byte of the frame;
//   frame_crc updated in the frame_done cycle, held until the next frame_done.
//  Undefined: no CRC logic; frame_crc tied 16'h0000.
// STRUCTURE
//  Package dvp_pkg: state encoding, pattern_sel codes, RGB565 bar-colour constants, CRC polynomial/init.
//  Sub-module dvp_pixel_src: combinational (x, y, pattern, frame_cnt) -> 16-bit RGB565 pixel.
//  Top holds FSM, hcnt/vcnt, frame_cnt, byte mux, optional CRC register.
// TESTING (bench params H_ACTIVE=8,H_BLANK=4,V_SYNC=1,V_BACK=1,V_ACTIVE=2,V_FRONT=1; LINE_LEN=20)
//  1 capture=1 one cycle from IDLE, sel=0 -> Vsyn high 20 cycles, Href 16-cycle bursts x2, frame_done at cycle 100, then IDLE.
//  2 sel=0 -> line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00 (one pixel per bar).
//  3 capture held 3 frames, sel=2 -> back-to-back frames, data bytes 00/01/02 per frame, frame_done every 100 cycles.
//  4 rst low at cycle 50 of active frame -> all outputs 0 same cycle; release + capture -> clean full frame.
//  5 sel changed 0->3 mid-frame -> current frame bars; next frame checkerboard; capture dropped mid-frame -> frame completes.
//  6 CRC_EN, sel=2 frame 0 (32 zero bytes) -> frame_crc equals golden model; undefined -> frame_crc==0.

Source files
------------

// File: rtl/dvp_pkg.sv
// ----------------------------------------------------------------------------
// dvp_pkg
//   Shared definitions for the DVP test-frame generator:
//   FSM state encoding, pattern_sel codes, RGB565 bar colours, and the
//   CRC-16-CCITT constants with a one-byte update helper (MSB first).
// ----------------------------------------------------------------------------
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4
    } state_t;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_FILL  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Shift one byte into the CRC, most significant bit first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/dvp_pixel_src.sv
// ----------------------------------------------------------------------------
// dvp_pixel_src
//   Combinational test-pattern source: (x, y, pattern, frame_cnt) -> RGB565.
//   Ports:
//     i_x, i_y      pixel coordinates within the active window
//     i_pattern     0 bars, 1 gradient, 2 frame-count fill, 3 checkerboard
//     i_frame_cnt   frame counter used by the fill pattern
//     o_pixel       16-bit RGB565 pixel
// ----------------------------------------------------------------------------
module dvp_pixel_src
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [1:0]  i_pattern,
    input  logic [7:0]  i_frame_cnt,
    output logic [15:0] o_pixel
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [15:0] w_bar_idx;
    logic        w_unused_y;

    // Only the low five y bits feed any pattern.
    assign w_unused_y = ^i_y[15:5];

    always_comb begin
        w_bar_idx = i_x / 16'(BAR_W);
        o_pixel   = RGB_BLACK;
        case (i_pattern)
            PAT_BARS: begin
                // Any leftover columns past the eighth bar stay black.
                case (w_bar_idx)
                    16'd0:   o_pixel = RGB_WHITE;
                    16'd1:   o_pixel = RGB_YELLOW;
                    16'd2:   o_pixel = RGB_CYAN;
                    16'd3:   o_pixel = RGB_GREEN;
                    16'd4:   o_pixel = RGB_MAGENTA;
                    16'd5:   o_pixel = RGB_RED;
                    16'd6:   o_pixel = RGB_BLUE;
                    default: o_pixel = RGB_BLACK;
                endcase
            end
            PAT_GRAD:  o_pixel = {i_x[4:0], i_x[5:0], i_y[4:0]};
            PAT_FILL:  o_pixel = {i_frame_cnt, i_frame_cnt};
            default:   o_pixel = (i_x[3] ^ i_y[3]) ? RGB_WHITE : RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/dvp_frame_gen.sv
// ----------------------------------------------------------------------------
// dvp_frame_gen
//   Camera-side DVP transmitter producing OV7670-style frames (Vsyn, Href,
//   8-bit RGB565 bytes, high byte first) from internal test patterns.
//   Optional feature macro: DVP_FRAME_GEN_CRC_EN (CRC-16-CCITT of each
//   frame's Href bytes on frame_crc; otherwise frame_crc is 0).
//   Ports:
//     clk          byte clock, all outputs registered on posedge
//     rst          asynchronous reset, active low
//     capture      level, 1 = run frames back to back
//     pattern_sel  test pattern, latched at each frame start
//     Vsyn         frame sync, active high
//     Href         high during active data bytes only
//     data         pixel byte, 0 whenever Href is low
//     frame_done   one-cycle pulse on the last cycle of the front porch
//     busy         high from the first Vsyn cycle until back in idle
//     frame_crc    CRC of the last completed frame
//     o_dbg_state  current FSM state
//   Outputs are registered from the FSM/counters, so they trail the state
//   by one cycle: capture seen at edge t gives Vsyn/busy from edge t+1.
// ----------------------------------------------------------------------------
module dvp_frame_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic [1:0]  pattern_sel,
    output logic        Vsyn,
    output logic        Href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic        busy,
    output logic [15:0] frame_crc,
    output state_t      o_dbg_state
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int VW       = $clog2(V_MAX + 1);

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW:0]   H_DATA = (HW + 1)'(2 * H_ACTIVE);

    state_t          r_state;
    state_t          w_state_nx;
    logic [HW-1:0]   r_hcnt;
    logic [VW-1:0]   r_vcnt;
    logic [VW-1:0]   w_lines_m1;
    logic [1:0]      r_pattern;
    logic [7:0]      r_frame_cnt;
    logic            w_line_end;
    logic            w_state_end;
    logic            w_frame_start;
    logic            w_vsyn;
    logic            w_href;
    logic            w_frame_done;
    logic            w_busy;
    logic [15:0]     w_pixel;
    logic [7:0]      w_byte;

    logic            r_vsyn;
    logic            r_href;
    logic [7:0]      r_data;
    logic            r_frame_done;
    logic            r_busy;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        case (r_state)
            ST_SYNC:   w_lines_m1 = VW'(V_SYNC - 1);
            ST_BACK:   w_lines_m1 = VW'(V_BACK - 1);
            ST_ACTIVE: w_lines_m1 = VW'(V_ACTIVE - 1);
            ST_FRONT:  w_lines_m1 = VW'(V_FRONT - 1);
            default:   w_lines_m1 = '0;
        endcase
    end

    assign w_line_end  = (r_hcnt == H_LAST);
    assign w_state_end = w_line_end && (r_vcnt == w_lines_m1);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (capture)     w_state_nx = ST_SYNC;
            ST_SYNC:   if (w_state_end) w_state_nx = ST_BACK;
            ST_BACK:   if (w_state_end) w_state_nx = ST_ACTIVE;
            ST_ACTIVE: if (w_state_end) w_state_nx = ST_FRONT;
            ST_FRONT:  if (w_state_end) w_state_nx = capture ? ST_SYNC : ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // A frame starts either from idle or directly out of the front porch.
    assign w_frame_start = capture &&
                           ((r_state == ST_IDLE) ||
                            ((r_state == ST_FRONT) && w_state_end));

    // ---------------- FSM: outputs (pre-register) ----------------
    always_comb begin
        w_vsyn       = (r_state == ST_SYNC);
        w_href       = (r_state == ST_ACTIVE) && ({1'b0, r_hcnt} < H_DATA);
        w_frame_done = (r_state == ST_FRONT) && w_state_end;
        w_busy       = (r_state != ST_IDLE);
        // Even hcnt carries the high byte of pixel hcnt>>1.
        w_byte       = r_hcnt[0] ? w_pixel[7:0] : w_pixel[15:8];
    end

    // ---------------- line / frame counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_pattern   <= PAT_BARS;
            r_frame_cnt <= 8'd0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_hcnt <= '0;
                r_vcnt <= '0;
            end else begin
                r_hcnt <= w_line_end ? '0 : r_hcnt + HW'(1);
                if (w_state_end) begin
                    r_vcnt <= '0;
                end else if (w_line_end) begin
                    r_vcnt <= r_vcnt + VW'(1);
                end
            end
            if (w_frame_start) begin
                r_pattern <= pattern_sel;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    dvp_pixel_src #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel_src (
        .i_x         (16'(r_hcnt >> 1)),
        .i_y         (16'(r_vcnt)),
        .i_pattern   (r_pattern),
        .i_frame_cnt (r_frame_cnt),
        .o_pixel     (w_pixel)
    );

    // ---------------- registered DVP outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vsyn       <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_vsyn       <= w_vsyn;
            r_href       <= w_href;
            r_data       <= w_href ? w_byte : 8'h00;
            r_frame_done <= w_frame_done;
            r_busy       <= w_busy;
        end
    end

    assign Vsyn        = r_vsyn;
    assign Href        = r_href;
    assign data        = r_data;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

`ifdef DVP_FRAME_GEN_CRC_EN
    logic [15:0] r_crc_run;
    logic [15:0] r_crc_out;

    // The running CRC restarts during sync; it is complete long before the
    // front porch ends, so it is published together with frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc_run <= CRC_INIT;
            r_crc_out <= 16'h0000;
        end else begin
            if (r_state == ST_SYNC) begin
                r_crc_run <= CRC_INIT;
            end else if (w_href) begin
                r_crc_run <= crc16_byte(r_crc_run, w_byte);
            end
            if (w_frame_done) begin
                r_crc_out <= r_crc_run;
            end
        end
    end

    assign frame_crc = r_crc_out;
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_dvp_frame_gen.sv
// ----------------------------------------------------------------------------
// tb_dvp_frame_gen
//   Directed bench for dvp_frame_gen with a small frame geometry:
//   H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1,
//   so LINE_LEN=20 and a frame is 100 cycles. Output cycle 1 is the first
//   Vsyn cycle; Href bursts are cycles 41..56 and 61..76; frame_done is
//   cycle 100.
// ----------------------------------------------------------------------------
module tb_dvp_frame_gen;
    import dvp_pkg::*;

    localparam int NREC = 400;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        capture;
    logic [1:0]  pattern_sel;
    logic        Vsyn;
    logic        Href;
    logic [7:0]  data;
    logic        frame_done;
    logic        busy;
    logic [15:0] frame_crc;
    state_t      dbg_state;

    always #5 clk = ~clk;

    dvp_frame_gen #(
        .H_ACTIVE (8),
        .H_BLANK  (4),
        .V_SYNC   (1),
        .V_BACK   (1),
        .V_ACTIVE (2),
        .V_FRONT  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .pattern_sel (pattern_sel),
        .Vsyn        (Vsyn),
        .Href        (Href),
        .data        (data),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_crc   (frame_crc),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  bars_bytes[16];

    logic        rec_vs[NREC+1];
    logic        rec_hr[NREC+1];
    logic [7:0]  rec_dt[NREC+1];
    logic        rec_fd[NREC+1];
    logic        rec_bz[NREC+1];
    logic [15:0] rec_crc[NREC+1];

    logic [15:0] crc_a;
    logic [15:0] crc_b;
    logic [15:0] crc_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record outputs for ncyc cycles; optionally drop capture or change
    // pattern_sel right after sampling the given cycle.
    task automatic record(input int ncyc, input int drop_at, input int sel_at,
                          input logic [1:0] new_sel);
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            rec_vs[i]  = Vsyn;
            rec_hr[i]  = Href;
            rec_dt[i]  = data;
            rec_fd[i]  = frame_done;
            rec_bz[i]  = busy;
            rec_crc[i] = frame_crc;
            if (i == drop_at) capture = 1'b0;
            if (i == sel_at)  pattern_sel = new_sel;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] crc_model(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input logic [7:0] fill,
                                            input int idx, input int line);
        logic [15:0] pix;
        logic [15:0] xv;
        logic [15:0] yv;
        xv = 16'(idx / 2);
        yv = 16'(line);
        case (mode)
            1:       pix = {xv[4:0], xv[5:0], yv[4:0]};
            2:       pix = {fill, fill};
            3:       pix = (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
            default: pix = 16'h0000;
        endcase
        if (mode == 0) return bars_bytes[idx];
        return (idx % 2 == 0) ? pix[15:8] : pix[7:0];
    endfunction

    // Check one recorded frame whose first Vsyn cycle is base+1.
    task automatic check_frame(input int base, input int mode, input logic [7:0] fill,
                               output logic [15:0] crc_exp);
        logic [15:0] crc;
        logic [7:0]  b;
        crc = 16'hFFFF;
        exp_q.delete();
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 16; i++) begin
                b = exp_byte(mode, fill, i, ln);
                exp_q.push_back(b);
                crc = crc_model(crc, b);
            end
        end
`ifdef DVP_FRAME_GEN_CRC_EN
        crc_exp = crc;
`else
        crc_exp = 16'h0000;
`endif
        for (int c = 1; c <= 100; c++) begin
            int r;
            bit ev;
            bit eh;
            r  = base + c;
            ev = (c <= 20);
            eh = (c >= 41 && c <= 56) || (c >= 61 && c <= 76);
            chk($sformatf("vsyn@%0d", r), 32'(rec_vs[r]), 32'(ev));
            chk($sformatf("href@%0d", r), 32'(rec_hr[r]), 32'(eh));
            chk($sformatf("frame_done@%0d", r), 32'(rec_fd[r]), 32'(c == 100));
            chk($sformatf("busy@%0d", r), 32'(rec_bz[r]), 32'd1);
            if (eh) chk($sformatf("data@%0d", r), 32'(rec_dt[r]), 32'(exp_q.pop_front()));
            else    chk($sformatf("data_blank@%0d", r), 32'(rec_dt[r]), 32'd0);
        end
        chk($sformatf("frame_crc@%0d", base + 100), 32'(rec_crc[base + 100]), 32'(crc_exp));
    endtask

    task automatic check_idle(input int from, input int to);
        for (int r = from; r <= to; r++) begin
            chk($sformatf("idle_busy@%0d", r), 32'(rec_bz[r]), 32'd0);
            chk($sformatf("idle_vsyn@%0d", r), 32'(rec_vs[r]), 32'd0);
            chk($sformatf("idle_href@%0d", r), 32'(rec_hr[r]), 32'd0);
            chk($sformatf("idle_data@%0d", r), 32'(rec_dt[r]), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vsyn"}, 32'(Vsyn), 32'd0);
        chk({tag, "_href"}, 32'(Href), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_crc"}, 32'(frame_crc), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bars_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                       8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        rst         = 1'b0;
        capture     = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Single frame of bars from a one-cycle capture pulse.
        capture = 1'b1; pattern_sel = 2'd0;
        tick();
        chk("latency_vsyn", 32'(Vsyn), 32'd0);
        chk("latency_busy", 32'(busy), 32'd0);
        capture = 1'b0;
        record(110, 0, 0, 2'd0);
        check_frame(0, 0, 8'h00, crc_a);
        chk("crc_before_done", 32'(rec_crc[99]), 32'd0);
        check_idle(101, 110);

        // Three back-to-back fill frames from a fresh reset; capture
        // drops inside the third frame.
        rst = 1'b0; tick(); rst = 1'b1; tick();
        capture = 1'b1; pattern_sel = 2'd2;
        tick();
        record(320, 250, 0, 2'd0);
        check_frame(0,   2, 8'h00, crc_a);
        check_frame(100, 2, 8'h01, crc_b);
        check_frame(200, 2, 8'h02, crc_c);
        chk("crc_reset_hold", 32'(rec_crc[99]), 32'd0);
        chk("crc_hold_f0", 32'(rec_crc[199]), 32'(crc_a));
        chk("crc_hold_f1", 32'(rec_crc[299]), 32'(crc_b));
        chk("crc_hold_idle", 32'(rec_crc[320]), 32'(crc_c));
        check_idle(301, 320);

        // Asynchronous reset in the middle of an active line.
        capture = 1'b1; pattern_sel = 2'd0;
        tick();
        capture = 1'b0;
        repeat (50) tick();
        chk("pre_reset_href", 32'(Href), 32'd1);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        rst = 1'b1;
        tick();
        capture = 1'b1; pattern_sel = 2'd0;
        tick();
        capture = 1'b0;
        record(110, 0, 0, 2'd0);
        check_frame(0, 0, 8'h00, crc_a);
        check_idle(101, 110);

        // pattern_sel changes mid-frame (bars then checkerboard), capture
        // drops inside the second frame which must still complete.
        capture = 1'b1; pattern_sel = 2'd0;
        tick();
        record(220, 150, 30, 2'd3);
        check_frame(0,   0, 8'h00, crc_a);
        check_frame(100, 3, 8'h00, crc_b);
        check_idle(201, 220);

        // Gradient frame.
        capture = 1'b1; pattern_sel = 2'd1;
        tick();
        capture = 1'b0;
        record(110, 0, 0, 2'd0);
        check_frame(0, 1, 8'h00, crc_a);
        check_idle(101, 110);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
